mips_debug_loader: RTL
======================

# mips_debug_loader

Host-side debug controller sitting directly upstream of `top_mips`. It consumes a byte stream from a UART receiver, decodes single-byte commands, assembles 32-bit instruction words and writes them into the pipeline's instruction memory. It then drives the pipeline enable (free-run or single-step) and dumps the register file back to a UART transmitter. It produces the `i_enable`, `i_write`, `i_address` and `i_instruction` stimulus that `top_mips` expects.

## Interface
Parameters:
- `NB_DATA`, 32, instruction/register data width
- `NB_ADDR`, 32, instruction memory address width (byte address)
- `NB_REG`, 5, register index width
- `NB_BYTE`, 8, UART byte width
- `MAX_INST`, 256, instruction memory depth in words

Ports:
- `i_clk`  in  1  single clock
- `i_reset`  in  1  synchronous, active-high reset
- `i_rx_data`  in  8  received byte
- `i_rx_valid`  in  1  one-cycle strobe, `i_rx_data` valid
- `i_halt`  in  1  pipeline retired HALT (0x00000000)
- `i_data_read_debug`  in  32  register-file debug read data
- `i_tx_ready`  in  1  transmitter can accept a byte
- `o_tx_data`  out  8  byte to transmit
- `o_tx_valid`  out  1  `o_tx_data` valid
- `o_enable`  out  1  pipeline clock enable, to `top_mips.i_enable`
- `o_write`  out  1  instruction-memory write strobe
- `o_address`  out  32  instruction-memory byte address
- `o_instruction`  out  32  instruction word to write
- `o_address_read_debug`  out  5  register index for debug read

## Operation
- Commands are accepted only in IDLE, as any `i_rx_valid` byte:
  - `0x4C` 'L' starts a load.
  - `0x52` 'R' starts a free run.
  - `0x53` 'S' performs a single step.
  - `0x44` 'D' starts a dump.
  - Any other byte is ignored.
- States: IDLE, LOAD, LOAD_WR, RUN, STEP, DUMP_RD, DUMP_TX, ACK.
- LOAD:
  - Each byte is shifted into a 32-bit assembly register, MSB first.
  - A 2-bit byte counter tracks the position; on the 4th byte the state goes to LOAD_WR.
- LOAD_WR:
  - `o_write`=1 for one cycle, with `o_address` = word_ptr×4 and `o_instruction` = assembled word.
  - If the word is 0x00000000 (HALT), the load terminates: ack 'K' (0x4B), word_ptr cleared.
  - Else word_ptr increments. If it reaches MAX_INST, the load terminates with ack 'E' (0x45). Otherwise the state returns to LOAD.
- RUN: `o_enable`=1 every cycle until `i_halt` is sampled high, then ack 'H' (0x48).
- STEP: `o_enable`=1 for exactly one cycle, then ack 'K'.
- DUMP:
  - For reg = 0..31: DUMP_RD drives `o_address_read_debug` = reg and waits one cycle.
  - DUMP_TX latches `i_data_read_debug` and sends 4 bytes, MSB first.
  - After reg 31 the state returns to IDLE with no ack.
- ACK: present the ack byte and hold until accepted, then go to IDLE.
- Bytes arriving outside IDLE/LOAD are dropped.

## Timing
- Reset values:
  - `o_enable`=0, `o_write`=0, `o_tx_valid`=0.
  - `o_address`, `o_instruction`, `o_tx_data`, `o_address_read_debug` = 0.
  - State IDLE; word_ptr, byte counter and assembly register = 0.
- Reset mid-operation: everything returns to reset values at the next edge. A partial word is discarded. A pending tx byte is withdrawn.
- All outputs are registered.
- Load latency: `o_write` asserts the cycle after the 4th `i_rx_valid` is sampled. `o_address`/`o_instruction` are stable during that cycle.
- An 'L' byte and the first data byte may arrive on consecutive cycles; no byte is lost.
- Tx handshake:
  - A byte transfers on an edge where `o_tx_valid`&&`i_tx_ready`.
  - `o_tx_data` must not change while `o_tx_valid`=1 and the byte is not yet accepted.
  - `o_tx_valid` drops the cycle after the last byte is accepted.
- Debug read: data is sampled exactly one cycle after `o_address_read_debug` changes.
- RUN with `i_halt` high on the first RUN cycle: `o_enable` is high for exactly that one cycle.
- `i_halt` is ignored outside RUN.

## Structure
- Shared package `mips_debug_pkg`:
  - state encoding;
  - command bytes L/R/S/D;
  - ack bytes K/E/H;
  - HALT opcode constant 0x00000000.
- One sub-module, `debug_tx_serializer`: takes a 32-bit word plus start, and emits 4 handshaked bytes MSB first with a done pulse. It is shared by DUMP_TX and ACK (ACK uses a 1-byte mode).

## Test plan
- Load: 'L', then 00 22 18 20, then 00 00 00 00 -> two `o_write` pulses:
  - address 0x0 with data 0x00221820;
  - address 0x4 with data 0x00000000;
  - then tx 0x4B.
- Overflow: with MAX_INST=4, load 4 non-zero words -> 4 writes, tx 0x45, state IDLE.
- Run: 'R', `i_halt` asserted 10 cycles later -> `o_enable` high exactly 10 cycles, then tx 0x48. The same with `i_halt` high immediately gives 1 cycle.
- Step and dump:
  - 'S' -> `o_enable` high exactly 1 cycle, then tx 0x4B.
  - 'D' with a register model returning reg×0x01010101 -> 128 bytes; reg 2 yields 02 02 02 02.
  - `i_tx_ready` toggled randomly -> no byte lost or duplicated.
- Reset mid-load: 'L' plus 2 bytes, `i_reset` for 1 cycle, then 'L' 00 00 00 01 00 00 00 00 -> first write at address 0x0 with data 0x00000001.
- Unknown byte 0x7A in IDLE and bytes received during RUN -> no output activity.

Source files
------------

// File: rtl/mips_debug_pkg.sv
// Shared encodings for the MIPS debug loader: FSM states, host command bytes,
// acknowledge bytes and the HALT opcode that terminates a program load.
package mips_debug_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_LOAD_WR = 3'd2;
  localparam logic [2:0] ST_RUN     = 3'd3;
  localparam logic [2:0] ST_STEP    = 3'd4;
  localparam logic [2:0] ST_DUMP_RD = 3'd5;
  localparam logic [2:0] ST_DUMP_TX = 3'd6;
  localparam logic [2:0] ST_ACK     = 3'd7;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_DUMP = 8'h44;

  localparam logic [7:0] ACK_OK   = 8'h4B;
  localparam logic [7:0] ACK_ERR  = 8'h45;
  localparam logic [7:0] ACK_HALT = 8'h48;

  localparam logic [31:0] HALT_OP = 32'h0000_0000;

endpackage

// File: rtl/mips_debug_loader_tx.sv
// Byte serializer for the debug UART: sends a word MSB first (or only its low
// byte in one-byte mode) over a valid/ready handshake, then pulses done.
module debug_tx_serializer #(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               one_byte,
  input  logic [NB_DATA-1:0] word,
  input  logic               tx_ready,
  output logic [NB_BYTE-1:0] tx_data,
  output logic               tx_valid,
  output logic               done
);
  localparam int NBYTES = NB_DATA / NB_BYTE;
  localparam int NB_CNT = $clog2(NBYTES);

  logic [NB_DATA-1:0] shreg;
  logic [NB_CNT-1:0]  left;

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg    <= '0;
      left     <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (tx_valid) begin
        // tx_data only moves on an accepting edge, so it is stable while stalled
        if (tx_ready) begin
          if (left == '0) begin
            tx_valid <= 1'b0;
            done     <= 1'b1;
          end else begin
            tx_data <= shreg[NB_DATA-1 -: NB_BYTE];
            shreg   <= shreg << NB_BYTE;
            left    <= left - 1'b1;
          end
        end
      end else if (start) begin
        tx_valid <= 1'b1;
        if (one_byte) begin
          tx_data <= word[NB_BYTE-1:0];
          shreg   <= '0;
          left    <= '0;
        end else begin
          tx_data <= word[NB_DATA-1 -: NB_BYTE];
          shreg   <= word << NB_BYTE;
          left    <= NB_CNT'(NBYTES - 1);
        end
      end
    end
  end

endmodule

// File: rtl/mips_debug_loader.sv
// Host-side debug controller for top_mips: loads program words from the UART
// byte stream, runs or single-steps the pipeline, and dumps the register file.
module mips_debug_loader
  import mips_debug_pkg::*;
#(
  parameter int NB_DATA  = 32,
  parameter int NB_ADDR  = 32,
  parameter int NB_REG   = 5,
  parameter int NB_BYTE  = 8,
  parameter int MAX_INST = 256
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  input  logic               i_halt,
  input  logic [NB_DATA-1:0] i_data_read_debug,
  input  logic               i_tx_ready,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  output logic               o_enable,
  output logic               o_write,
  output logic [NB_ADDR-1:0] o_address,
  output logic [NB_DATA-1:0] o_instruction,
  output logic [NB_REG-1:0]  o_address_read_debug
);
  localparam int NB_PTR = $clog2(MAX_INST) + 1;

  logic [2:0]         state;
  logic [1:0]         byte_cnt;
  logic [NB_DATA-1:0] asm_word;
  logic [NB_DATA-1:0] asm_next;
  logic [NB_PTR-1:0]  word_ptr;
  logic               tx_start;
  logic               tx_one;
  logic [NB_DATA-1:0] tx_word;
  logic               tx_done;

  assign asm_next = {asm_word[NB_DATA-NB_BYTE-1:0], i_rx_data};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state                <= ST_IDLE;
      byte_cnt             <= '0;
      asm_word             <= '0;
      word_ptr             <= '0;
      tx_start             <= 1'b0;
      tx_one               <= 1'b0;
      tx_word              <= '0;
      o_enable             <= 1'b0;
      o_write              <= 1'b0;
      o_address            <= '0;
      o_instruction        <= '0;
      o_address_read_debug <= '0;
    end else begin
      tx_start <= 1'b0;
      o_write  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_rx_valid) begin
            case (i_rx_data)
              CMD_LOAD: begin
                byte_cnt <= '0;
                state    <= ST_LOAD;
              end
              CMD_RUN: begin
                o_enable <= 1'b1;
                state    <= ST_RUN;
              end
              CMD_STEP: begin
                o_enable <= 1'b1;
                state    <= ST_STEP;
              end
              CMD_DUMP: begin
                o_address_read_debug <= '0;
                state                <= ST_DUMP_RD;
              end
              default: ;
            endcase
          end
        end
        ST_LOAD: begin
          if (i_rx_valid) begin
            asm_word <= asm_next;
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == 2'd3) begin
              o_write       <= 1'b1;
              o_address     <= NB_ADDR'(word_ptr) << 2;
              o_instruction <= asm_next;
              state         <= ST_LOAD_WR;
            end
          end
        end
        ST_LOAD_WR: begin
          if (o_instruction == NB_DATA'(HALT_OP)) begin
            word_ptr <= '0;
            tx_word  <= NB_DATA'(ACK_OK);
            tx_one   <= 1'b1;
            tx_start <= 1'b1;
            state    <= ST_ACK;
          end else if (word_ptr == NB_PTR'(MAX_INST - 1)) begin
            // Memory full: restart from word 0 on the next load
            word_ptr <= '0;
            tx_word  <= NB_DATA'(ACK_ERR);
            tx_one   <= 1'b1;
            tx_start <= 1'b1;
            state    <= ST_ACK;
          end else begin
            word_ptr <= word_ptr + 1'b1;
            state    <= ST_LOAD;
          end
        end
        ST_RUN: begin
          if (i_halt) begin
            o_enable <= 1'b0;
            tx_word  <= NB_DATA'(ACK_HALT);
            tx_one   <= 1'b1;
            tx_start <= 1'b1;
            state    <= ST_ACK;
          end
        end
        ST_STEP: begin
          o_enable <= 1'b0;
          tx_word  <= NB_DATA'(ACK_OK);
          tx_one   <= 1'b1;
          tx_start <= 1'b1;
          state    <= ST_ACK;
        end
        ST_DUMP_RD: begin
          // Register address has been stable for one cycle; capture its data
          tx_word  <= i_data_read_debug;
          tx_one   <= 1'b0;
          tx_start <= 1'b1;
          state    <= ST_DUMP_TX;
        end
        ST_DUMP_TX: begin
          if (tx_done) begin
            if (o_address_read_debug == '1) begin
              state <= ST_IDLE;
            end else begin
              o_address_read_debug <= o_address_read_debug + 1'b1;
              state                <= ST_DUMP_RD;
            end
          end
        end
        ST_ACK: begin
          if (tx_done) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  debug_tx_serializer #(
    .NB_DATA(NB_DATA),
    .NB_BYTE(NB_BYTE)
  ) u_tx (
    .clk      (i_clk),
    .reset    (i_reset),
    .start    (tx_start),
    .one_byte (tx_one),
    .word     (tx_word),
    .tx_ready (i_tx_ready),
    .tx_data  (o_tx_data),
    .tx_valid (o_tx_valid),
    .done     (tx_done)
  );

endmodule
